// File: rtl/decoder_nto2n_seq_if.sv
// Command/status bundle for decoder_nto2n_seq.
// Latency: none (wires only).
// Backpressure: none; commands are sampled on every enabled clock edge.
// Ports: en, load, sel, scan_start, scan_stop (controller -> decoder);
//        d, idx, busy, valid and optional wrap (decoder -> controller).
// Macro DEC_WRAP_PULSE_EN adds the wrap status bit.
interface decoder_nto2n_seq_if #(
    parameter int N = 2
);
    localparam int W = 1 << N;

    logic         en;
    logic         load;
    logic [N-1:0] sel;
    logic         scan_start;
    logic         scan_stop;
    logic [W-1:0] d;
    logic [N-1:0] idx;
    logic         busy;
    logic         valid;
`ifdef DEC_WRAP_PULSE_EN
    logic         wrap;

    modport master (output en, load, sel, scan_start, scan_stop,
                    input  d, idx, busy, valid, wrap);
    modport slave  (input  en, load, sel, scan_start, scan_stop,
                    output d, idx, busy, valid, wrap);
`else
    modport master (output en, load, sel, scan_start, scan_stop,
                    input  d, idx, busy, valid);
    modport slave  (input  en, load, sel, scan_start, scan_stop,
                    output d, idx, busy, valid);
`endif
endinterface

// File: rtl/decoder_nto2n_seq.sv
// N-to-2^N one-hot decoder with manual hold and timed auto-scan modes.
// Latency: 1 cycle from an enabled command to the registered d/idx/busy/valid.
// Backpressure: none; en=0 freezes all state, scan resumes where it paused.
// Ports: clk, rst (synchronous, active-high); bus (slave modport) carrying
//        en/load/sel/scan_start/scan_stop in and d/idx/busy/valid out.
// Macro DEC_WRAP_PULSE_EN adds a one-cycle wrap pulse when a scan returns to index 0.
module decoder_nto2n_seq #(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               rst,
    decoder_nto2n_seq_if.slave bus
);
    localparam int W = 1 << N;
    localparam logic [7:0]   CNT_LAST = 8'(DWELL - 1);
    localparam logic [N-1:0] IDX_LAST = {N{1'b1}};
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] idx_q,   idx_d;
    logic [7:0]   cnt_q,   cnt_d;
    logic [W-1:0] d_q,     d_d;
    logic         busy_q,  busy_d;
    logic         valid_q, valid_d;
`ifdef DEC_WRAP_PULSE_EN
    logic         wrap_q,  wrap_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifdef DEC_WRAP_PULSE_EN
        // Holds with the rest of the state while en is low.
        wrap_d  = wrap_q;
`endif
        if (bus.en) begin
`ifdef DEC_WRAP_PULSE_EN
            wrap_d = 1'b0;
`endif
            if (bus.scan_stop) begin
                state_d = ST_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_HOLD: begin
                        if (bus.scan_start) begin
                            state_d = ST_SCAN;
                            idx_d   = '0;
                            cnt_d   = '0;
                        end else if (bus.load) begin
                            state_d = ST_HOLD;
                            idx_d   = bus.sel;
                        end
                    end
                    ST_SCAN: begin
                        // load and scan_start are deliberately ignored here.
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            idx_d = idx_q + 1'b1;   // natural wrap W-1 -> 0
`ifdef DEC_WRAP_PULSE_EN
                            wrap_d = (idx_q == IDX_LAST);
`endif
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
        // Outputs are decoded from next state so they can be registered.
        d_d     = (state_d == ST_IDLE) ? '0 : (ONE << idx_d);
        busy_d  = (state_d == ST_SCAN);
        valid_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef DEC_WRAP_PULSE_EN
            wrap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
`ifdef DEC_WRAP_PULSE_EN
            wrap_q  <= wrap_d;
`endif
        end
    end

    assign bus.d     = d_q;
    assign bus.idx   = idx_q;
    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
`ifdef DEC_WRAP_PULSE_EN
    assign bus.wrap  = wrap_q;
`endif
endmodule

// File: doc/decoder_nto2n_seq.md
DECODER_NTO2N_SEQ -- requirements
Module: decoder_nto2n_seq

Interface
REQ-001 Parameter N, default 2, select width; legal range 2..6; output width W = 2**N.
REQ-002 Parameter DWELL, default 4, cycles each output stays asserted in scan mode; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  clock enable; low = all registers hold, all commands ignored.
REQ-006 load  input  1  capture sel and drive its one-hot decode (manual mode).
REQ-007 sel  input  N  binary code to decode on load.
REQ-008 scan_start  input  1  begin auto-scan from index 0.
REQ-009 scan_stop  input  1  end scan or hold; return outputs to zero.
REQ-010 d  output  W  registered one-hot decode; all-zero when idle.
REQ-011 idx  output  N  registered binary index currently decoded onto d.
REQ-012 busy  output  1  high while in SCAN state.
REQ-013 valid  output  1  high whenever d is non-zero (HOLD or SCAN).

Function
REQ-014 FSM states: IDLE (d=0), HOLD (d=onehot(idx)), SCAN (d=onehot(idx), idx advancing).
REQ-015 All outputs registered; d[k]=1 iff idx==k in HOLD/SCAN; exactly one bit of d set when valid=1.
REQ-016 Command priority per enabled cycle: scan_stop > scan_start > load.
REQ-017 IDLE or HOLD, load=1: next edge -> HOLD, idx<=sel, d<=onehot(sel); latency 1 cycle.
REQ-018 HOLD, load=1 with new sel: re-captures; d updates on the next edge with no zero cycle between.
REQ-019 IDLE or HOLD, scan_start=1: next edge -> SCAN, idx<=0, dwell counter<=0, d<=onehot(0).
REQ-020 SCAN: dwell counter increments each enabled cycle; at counter==DWELL-1 counter<=0 and idx<=idx+1, wrapping W-1 -> 0.
REQ-021 SCAN: each index held for exactly DWELL enabled cycles; full sweep = W*DWELL enabled cycles.
REQ-022 SCAN: load ignored; scan_start re-asserted ignored (no restart).
REQ-023 Any state, scan_stop=1: next edge -> IDLE, d=0, idx=0, counter=0, busy=0, valid=0.
REQ-024 scan_start and scan_stop same cycle: stop wins; result IDLE.
REQ-025 en=0: state, idx, d, counter frozen; scan timing resumes exactly where paused.
REQ-026 DWELL=1: idx advances every enabled cycle.

Reset
REQ-027 rst=1 at a rising edge: state IDLE, d=0, idx=0, busy=0, valid=0, counter=0, wrap=0 (when present); rst overrides en and all commands.
REQ-028 Reset mid-scan or mid-hold: outputs zero on the edge rst is sampled; no further command acted on that cycle.

Configuration
REQ-029 Macro DEC_WRAP_PULSE_EN defined: extra port wrap  output  1  registered one-cycle pulse coinciding with the first cycle d returns to onehot(0) after idx W-1 in SCAN; not raised on scan entry.
REQ-030 DEC_WRAP_PULSE_EN undefined: wrap port and its logic absent; all other behaviour identical.

Verification (N=2, DWELL=2 unless stated)
REQ-031 Reset then idle 5 cycles -> d=0000, idx=0, busy=0, valid=0 throughout.
REQ-032 load with sel=2 -> next cycle d=0100, idx=2, valid=1; load sel=3 -> d=1000 next cycle with no zero gap; scan_stop -> d=0000.
REQ-033 scan_start -> d sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001; with DEC_WRAP_PULSE_EN wrap=1 only on that ninth cycle.
REQ-034 Mid-scan en=0 for 3 cycles at d=0010 first dwell cycle -> d held 0010; after en=1 exactly one more 0010 cycle then 0100.
REQ-035 scan_start and scan_stop same cycle from HOLD d=0010 -> IDLE, d=0000; load during SCAN -> ignored, sequence unchanged.
REQ-036 rst asserted while scanning at d=1000 -> next edge all outputs zero; N=3, DWELL=1 scan -> d walks 8 one-hot codes, one per cycle, wraps to 00000001.
